pll_clock_monitor: RTL

//  - Checks from the 12 MHz reference domain that the PLL output (24 MHz) is actually running at rate.
//  - Input is a toggle signal generated in the PLL domain; it flips every 16 PLL cycles (0.75 MHz).
//  - The block counts toggle edges over a fixed reference window and asserts clk_ok after repeated good windows.
//  - Feeds board status/reset logic that gates the video path until the 24 MHz clock is trusted.

---
 rtl/pll_clock_monitor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pll_clock_monitor.sv
// PLL rate monitor: counts synchronised toggle edges per reference window and qualifies clk_ok.
// Optional sticky fault latch built only when CLKMON_STICKY_EN is defined.
module pll_clock_monitor #(
  parameter int unsigned WINDOW    = 4096,
  parameter int unsigned EXP_EDGES = 512,
  parameter int unsigned TOL       = 8,
  parameter int unsigned GOOD_N    = 4,
  parameter int unsigned BAD_N     = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             mon_toggle,
  input  logic             fault_clr,
  output logic             clk_ok,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             fault_pulse,
  output logic             fault_sticky
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned GC_W  = $clog2(GOOD_N + 1);
  localparam int unsigned BC_W  = $clog2(BAD_N + 1);
  localparam logic [CNT_W:0] LO_LIM = (EXP_EDGES > TOL) ? (CNT_W+1)'(EXP_EDGES - TOL) : '0;
  localparam logic [CNT_W:0] HI_LIM = (CNT_W+1)'(EXP_EDGES + TOL);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic {ACQUIRE, LOCKED} state_t;

  logic             sync1_q, sync2_q, sync3_q;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] run_q, run_d, run_inc;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic             valid_q;
  logic             fault_q, fault_d;
  logic [GC_W-1:0]  good_q, good_d;
  logic [BC_W-1:0]  bad_q, bad_d;
  state_t           state_q, state_d;
  logic             edge_det, win_close, win_good;

  // The edge seen in the last window cycle is folded into the closing count via run_inc.
  always_comb begin
    edge_det     = sync2_q ^ sync3_q;
    win_close    = (win_q == WIN_LAST);
    win_d        = win_close ? '0 : win_q + 1'b1;
    run_inc      = (edge_det && (run_q != '1)) ? run_q + 1'b1 : run_q;
    run_d        = win_close ? '0 : run_inc;
    edge_count_d = win_close ? run_inc : edge_count_q;
    win_good     = ({1'b0, run_inc} >= LO_LIM) && ({1'b0, run_inc} <= HI_LIM);
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    fault_d = 1'b0;
    if (win_close) begin
      case (state_q)
        ACQUIRE: begin
          if (!win_good) begin
            good_d = '0;
          end else if (good_q == GC_W'(GOOD_N - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          if ((run_inc == '0) || (!win_good && (bad_q == BC_W'(BAD_N - 1)))) begin
            state_d = ACQUIRE;
            fault_d = 1'b1;
            good_d  = '0;
            bad_d   = '0;
          end else if (!win_good) begin
            bad_d = bad_q + 1'b1;
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      win_q        <= '0;
      run_q        <= '0;
      edge_count_q <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      good_q       <= '0;
      bad_q        <= '0;
      state_q      <= ACQUIRE;
    end else begin
      sync1_q      <= mon_toggle;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      win_q        <= win_d;
      run_q        <= run_d;
      edge_count_q <= edge_count_d;
      valid_q      <= win_close;
      fault_q      <= fault_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      state_q      <= state_d;
    end
  end

  assign clk_ok      = (state_q == LOCKED);
  assign edge_count  = edge_count_q;
  assign count_valid = valid_q;
  assign fault_pulse = fault_q;

`ifdef CLKMON_STICKY_EN
  logic sticky_q;

  // A fault pulse outranks a simultaneous clear.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= fault_q | (sticky_q & ~fault_clr);
    end
  end

  assign fault_sticky = sticky_q;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign fault_sticky     = 1'b0;
`endif

endmodule
